// File: rtl/ray_pkg.sv
// Shared ray types and the round-robin unit search used by the dispatcher.
package ray_pkg;

  localparam int POSITION_WIDTH = 16;
  localparam int ADDRESS_WIDTH  = 32;
  localparam int MAX_UNITS      = 16;

  typedef struct packed {
    logic signed [POSITION_WIDTH-1:0] v2;
    logic signed [POSITION_WIDTH-1:0] v1;
    logic signed [POSITION_WIDTH-1:0] v0;
    logic [ADDRESS_WIDTH-1:0]         address;
  } ray_t;

  typedef struct packed {
    logic       found;
    logic [3:0] index;
  } pick_t;

  // First eligible unit scanning ptr, ptr+1, ... modulo num_units.
  function automatic pick_t rr_pick(input logic [MAX_UNITS-1:0] eligible,
                                    input logic [3:0] ptr,
                                    input int num_units);
    pick_t p;
    int    idx;
    p = '0;
    for (int i = 0; i < MAX_UNITS; i++) begin
      if (i < num_units && !p.found) begin
        idx = (int'(ptr) + i) % num_units;
        if (eligible[idx[3:0]]) begin
          p.found = 1'b1;
          p.index = idx[3:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ray_fifo.sv
// Synchronous ray FIFO; pointers wrap naturally because DEPTH is a power of two.
module ray_fifo
  import ray_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  ray_t                     push_data,
  output ray_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  ray_t           mem [DEPTH];
  logic [AW-1:0]  head_ptr;
  logic [AW-1:0]  tail_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  assign head  = mem[head_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ray_dispatcher.sv
// Buffers camera rays and launches each onto one idle ray unit, round-robin.
module ray_dispatcher #(
  parameter int POSITION_WIDTH = ray_pkg::POSITION_WIDTH,
  parameter int ADDRESS_WIDTH  = ray_pkg::ADDRESS_WIDTH,
  parameter int NUM_UNITS      = 4,
  parameter int DEPTH          = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic signed [POSITION_WIDTH-1:0] inV [2:0],
  input  logic [ADDRESS_WIDTH-1:0]         inAddress,
  input  logic                             inStart,
  output logic                             inReady,
  output logic                             busy,
  output logic signed [POSITION_WIDTH-1:0] unitV [2:0],
  output logic [ADDRESS_WIDTH-1:0]         unitAddress,
  output logic [NUM_UNITS-1:0]             unitStart,
  input  logic [NUM_UNITS-1:0]             unitReady,
  input  logic [NUM_UNITS-1:0]             unitBusy,
  output logic [31:0]                      dispatchCount
);
  import ray_pkg::*;

  ray_t                    in_ray;
  ray_t                    head_ray;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;
  logic [NUM_UNITS-1:0]    claim;
  logic [NUM_UNITS-1:0]    eligible;
  logic [3:0]              rr_ptr;
  pick_t                   pick;
  logic                    launch;

  assign in_ray.v0      = inV[0];
  assign in_ray.v1      = inV[1];
  assign in_ray.v2      = inV[2];
  assign in_ray.address = inAddress;

  ray_fifo #(.DEPTH(DEPTH)) fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inStart && inReady),
    .pop       (launch),
    .push_data (in_ray),
    .head      (head_ray),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign inReady  = !full;
  // A just-launched unit is masked for one cycle while it drops unitReady.
  assign eligible = unitReady & ~claim;
  assign pick     = rr_pick(MAX_UNITS'(eligible), rr_ptr, NUM_UNITS);
  assign launch   = !empty && pick.found;
  assign busy     = (count != '0) || (|unitStart) || (|unitBusy);

  always_ff @(posedge clock) begin
    if (reset) begin
      unitStart     <= '0;
      claim         <= '0;
      unitV[0]      <= '0;
      unitV[1]      <= '0;
      unitV[2]      <= '0;
      unitAddress   <= '0;
      rr_ptr        <= '0;
      dispatchCount <= '0;
    end else begin
      unitStart <= '0;
      claim     <= '0;
      if (launch) begin
        unitStart     <= NUM_UNITS'(1) << pick.index;
        claim         <= NUM_UNITS'(1) << pick.index;
        unitV[0]      <= head_ray.v0;
        unitV[1]      <= head_ray.v1;
        unitV[2]      <= head_ray.v2;
        unitAddress   <= head_ray.address;
        rr_ptr        <= (pick.index == 4'(NUM_UNITS-1)) ? 4'd0 : pick.index + 4'd1;
        dispatchCount <= dispatchCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Randomised and directed checks of ray_dispatcher against a queue-based model.
module tb_ray_dispatcher;

  localparam int PW = 16;
  localparam int AW = 32;
  localparam int N  = 4;
  localparam int D  = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic signed [PW-1:0] inV [2:0];
  logic [AW-1:0]        inAddress;
  logic                 inStart;
  logic                 inReady;
  logic                 busy;
  logic signed [PW-1:0] unitV [2:0];
  logic [AW-1:0]        unitAddress;
  logic [N-1:0]         unitStart;
  logic [N-1:0]         unitReady;
  logic [N-1:0]         unitBusy;
  logic [31:0]          dispatchCount;

  ray_dispatcher #(.POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .NUM_UNITS(N), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .inV(inV), .inAddress(inAddress), .inStart(inStart),
    .inReady(inReady), .busy(busy), .unitV(unitV), .unitAddress(unitAddress),
    .unitStart(unitStart), .unitReady(unitReady), .unitBusy(unitBusy),
    .dispatchCount(dispatchCount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PW-1:0] x, y, z;
    logic [AW-1:0] a;
  } ray_s;

  // Model: buffered rays, unit launched this cycle (-1 none), next rr start, launch count.
  ray_s        q [$];
  int          m_win = -1;
  int          m_rr  = 0;
  logic [31:0] m_cnt = '0;
  ray_s        m_data;
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [N-1:0] seq_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    return (w < 0) ? '0 : (N'(1) << w);
  endfunction

  task automatic tick();
    bit   acc;
    int   w, u;
    ray_s r;
    if (reset) begin
      q.delete();
      m_win = -1;
      m_rr  = 0;
      m_cnt = '0;
    end else begin
      acc = inStart && (q.size() != D);
      w = -1;
      if (q.size() > 0)
        for (int k = 0; k < N; k++) begin
          u = (m_rr + k) % N;
          if (w < 0 && unitReady[u] && m_win != u) w = u;
        end
      if (w >= 0) begin
        m_data = q.pop_front();
        m_rr   = (w + 1) % N;
        m_cnt  = m_cnt + 32'd1;
      end
      m_win = w;
      if (acc) begin
        r.x = inV[0]; r.y = inV[1]; r.z = inV[2]; r.a = inAddress;
        q.push_back(r);
      end
    end
    @(posedge clock);
    @(negedge clock);
    chk("inReady", inReady, q.size() != D);
    chk("unitStart", unitStart, onehot(m_win));
    chk("busy", busy, (q.size() != 0) || (m_win >= 0) || (|unitBusy));
    chk("dispatchCount", dispatchCount, m_cnt);
    if (m_win >= 0) begin
      chk("unitV0", {unitV[0]}, m_data.x);
      chk("unitV1", {unitV[1]}, m_data.y);
      chk("unitV2", {unitV[2]}, m_data.z);
      chk("unitAddress", unitAddress, m_data.a);
    end
    if (unitStart != '0) seq_log.push_back(unitStart);
  endtask

  task automatic do_reset();
    reset = 1'b1; inStart = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ray(input int k);
    inV[0] = PW'(k * 7); inV[1] = PW'(-k - 1); inV[2] = PW'(k * 311);
    inAddress = 32'h2000 + AW'(k);
  endtask

  initial begin
    int           sent;
    bit           will;
    logic [N-1:0] st [6];

    reset = 1'b1; inStart = 1'b0; inV[0] = '0; inV[1] = '0; inV[2] = '0;
    inAddress = '0; unitReady = '0; unitBusy = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", inReady, 1);
    chk("rst_start", unitStart, 0);
    chk("rst_cnt", dispatchCount, 0);
    chk("rst_addr", unitAddress, 0);
    chk("rst_busy", busy, 0);

    // single ray
    unitReady = '1; inStart = 1'b1;
    inV[0] = 100; inV[1] = -200; inV[2] = 300; inAddress = 32'h1000;
    tick();
    inStart = 1'b0;
    chk("single_lat1", unitStart, 0);
    tick();
    chk("single_start", unitStart, 4'b0001);
    chk("single_v0", {unitV[0]}, 16'd100);
    chk("single_v1", {unitV[1]}, 16'hFF38);
    chk("single_v2", {unitV[2]}, 16'd300);
    chk("single_addr", unitAddress, 32'h1000);
    chk("single_cnt", dispatchCount, 1);
    unitReady = 4'b1110; unitBusy = 4'b0001;
    tick();
    chk("single_once", unitStart, 0);
    chk("single_busy", busy, 1);
    unitBusy = '0; unitReady = '1;
    tick();
    chk("single_idle", busy, 0);

    // round robin, units drop ready after launch
    do_reset(); seq_log.delete(); unitReady = '1; sent = 0;
    for (int c = 0; c < 16; c++) begin
      inStart = (sent < 8); set_ray(sent);
      will = inStart && (q.size() != D);
      tick();
      if (will) sent++;
      unitReady &= ~onehot(m_win);
    end
    chk("rr_sent", sent, 8);
    chk("rr_n1", seq_log.size(), 4);
    for (int k = 0; k < 4 && k < seq_log.size(); k++) chk("rr_seq1", seq_log[k], N'(1) << k);
    inStart = 1'b0; unitReady = '1;
    for (int c = 0; c < 10; c++) begin
      tick();
      unitReady &= ~onehot(m_win);
    end
    chk("rr_n2", seq_log.size(), 8);
    for (int k = 4; k < 8 && k < seq_log.size(); k++) chk("rr_seq2", seq_log[k], N'(1) << (k - 4));

    // backpressure
    do_reset(); unitReady = '0; sent = 0;
    for (int c = 0; c < 8; c++) begin
      inStart = (sent < 5); set_ray(sent);
      will = inStart && (q.size() != D);
      tick();
      if (will) sent++;
    end
    chk("bp_accepted", sent, 4);
    chk("bp_ready", inReady, 0);
    chk("bp_nostart", unitStart, 0);
    unitReady = 4'b0100;
    tick();
    chk("bp_unit2", unitStart, 4'b0100);
    chk("bp_ray1", unitAddress, 32'h2000);
    chk("bp_reready", inReady, 1);
    unitReady = '0;
    will = inStart && (q.size() != D);
    tick();
    if (will) sent++;
    chk("bp_ray5", sent, 5);
    inStart = 1'b0; unitReady = '1;
    for (int c = 0; c < 12; c++) begin
      tick();
      unitReady &= ~onehot(m_win);
    end
    chk("bp_cnt", dispatchCount, 5);

    // simultaneous push and pop at count 2
    do_reset(); unitReady = '0; inStart = 1'b1;
    set_ray(10); tick();
    set_ray(11); tick();
    set_ray(12); unitReady = 4'b0001;
    tick();
    chk("sp_start", unitStart, 4'b0001);
    chk("sp_head", unitAddress, 32'h2000 + 10);
    unitReady = '0;
    set_ray(13); tick();
    set_ray(14); tick();
    chk("sp_full", inReady, 0);
    inStart = 1'b0; unitReady = '1;
    for (int c = 0; c < 12; c++) begin
      tick();
      unitReady &= ~onehot(m_win);
    end
    chk("sp_cnt", dispatchCount, 5);

    // claim mask: unit 0 keeps ready high
    do_reset(); unitReady = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      inStart = (c < 2); set_ray(20 + c);
      tick();
      st[c] = unitStart;
    end
    chk("claim_t1", st[1], 4'b0001);
    chk("claim_t2", st[2], 4'b0000);
    chk("claim_t3", st[3], 4'b0001);
    chk("claim_t4", st[4], 4'b0000);

    // reset mid-frame with a launch due
    do_reset(); unitReady = '0; inStart = 1'b1;
    for (int c = 0; c < 3; c++) begin set_ray(30 + c); tick(); end
    inStart = 1'b0; unitReady = '1; unitBusy = 4'b0010; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_nostart", unitStart, 0);
    tick(); tick();
    chk("mid_start", unitStart, 0);
    chk("mid_cnt", dispatchCount, 0);
    chk("mid_ready", inReady, 1);
    chk("mid_busy", busy, 1);
    unitBusy = '0;
    tick();
    chk("mid_idle", busy, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      inStart   = ($urandom_range(0, 3) != 0);
      inV[0]    = PW'($urandom); inV[1] = PW'($urandom); inV[2] = PW'($urandom);
      inAddress = $urandom;
      unitReady = N'($urandom) | (((c / 500) % 2 == 0) ? N'($urandom) : '0);
      if ($urandom_range(0, 1) == 1) unitReady &= ~onehot(m_win);
      unitBusy  = N'($urandom) & N'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_dispatcher.md
Name: ray_dispatcher

Overview:
- Sits directly downstream of the camera ray generator and upstream of NUM_UNITS parallel ray units.
- Accepts one ray per cycle (direction vector plus framebuffer pixel address) over a valid/ready handshake and buffers it in a small FIFO.
- Issues each ray to exactly one idle ray unit, choosing among units round-robin.
- Aggregates unit activity into a single busy flag so the generator can report frame completion.

Parameters:
- POSITION_WIDTH, 16, width of each signed ray-vector component.
- ADDRESS_WIDTH, 32, width of the pixel address.
- NUM_UNITS, 4, number of downstream ray units; range 1..16.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- inV  in  3 x POSITION_WIDTH signed  ray direction, index [2:0].
- inAddress  in  ADDRESS_WIDTH  pixel address.
- inStart  in  1  upstream valid.
- inReady  out  1  dispatcher can accept.
- busy  out  1  any ray buffered, launching or in flight.
- unitV  out  3 x POSITION_WIDTH signed  shared ray bus to all units.
- unitAddress  out  ADDRESS_WIDTH  shared address bus.
- unitStart  out  NUM_UNITS  one-hot launch pulse.
- unitReady  in  NUM_UNITS  per-unit idle flag.
- unitBusy  in  NUM_UNITS  per-unit working flag.
- dispatchCount  out  32  rays launched since reset (debug).

Behaviour:
- Reset: all outputs and state clear.
  - FIFO emptied; unitStart = 0; unitV = 0; unitAddress = 0; rrPtr = 0; dispatchCount = 0; claim mask = 0.
  - inReady is 1 in the cycle after reset deasserts.
- Reset mid-operation: buffered rays are discarded, and any launch pulse due the next cycle is suppressed. Ray units are not reset by this block.
- Accept: a transfer occurs on the rising edge where inStart && inReady.
  - inReady = (count != DEPTH), driven from registers only, with no combinational path from inStart.
  - When inStart is low, inV and inAddress are don't-care.
- FIFO: count, head pointer and tail pointer are registered and wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on empty never occurs.
  - Push when full never occurs, because inReady is low.
- Eligibility: unit i is eligible when unitReady[i] && !claim[i].
  - claim[i] is set in the cycle unitStart[i] is driven.
  - claim[i] is cleared the following cycle, which gives units one cycle to deassert unitReady.
- Dispatch, evaluated each cycle: if the FIFO is non-empty and any unit is eligible:
  - Pick the first eligible index scanning rrPtr, rrPtr+1, ... modulo NUM_UNITS.
  - At the clock edge, register the head entry onto unitV and unitAddress, set unitStart to one-hot(winner), and pop.
  - Set rrPtr <= (winner+1) mod NUM_UNITS and increment dispatchCount.
  - Otherwise unitStart <= 0, and unitV/unitAddress hold their previous values.
- unitStart is a single-cycle pulse. At most one launch per cycle.
- unitV and unitAddress are valid only while unitStart is non-zero.
- Latency: a ray accepted at edge t into an empty FIFO with an eligible unit shows unitStart high in the cycle after edge t+1. Minimum 2 edges, with no bypass path.
- Throughput: one ray per cycle sustained while units are available.
- busy = (count != 0) || (unitStart != 0) || (|unitBusy). This is combinational from registers and inputs.
- Ordering: rays leave in acceptance order. Completion order across units is not guaranteed.
- Widths: no arithmetic on ray data, which passes through bit-exact. dispatchCount wraps at 2^32.

Decomposition:
- Package ray_pkg holds:
  - POSITION_WIDTH and ADDRESS_WIDTH defaults.
  - ray_t, a packed struct of the 3 signed components plus the address, used for FIFO storage and shared with the generator.
  - A function that performs the round-robin first-eligible search.
- One sub-module, ray_fifo: a parameterised synchronous FIFO of ray_t with push, pop, full, empty and count.

Test Plan:
- Single ray: inV={100,-200,300}, inAddress=0x1000, all units ready → exactly one unitStart=0001 pulse, 2 edges after accept, carrying identical data; dispatchCount=1; busy falls once unitBusy clears.
- Round-robin: 8 back-to-back rays, units ready and units drop unitReady the cycle after launch → unitStart sequence 0001,0010,0100,1000 then waits; after units re-ready, the next 4 launch in the same order.
- Backpressure: all unitReady=0, push rays 1..5 with DEPTH=4 → inReady low after 4 accepts, ray 5 held by upstream; raise unitReady[2] only → ray 1 goes to unit 2, inReady reasserts, ray 5 is accepted, FIFO order is preserved.
- Simultaneous push/pop: FIFO count=2, push and dispatch on the same edge → count stays 2, no data corruption, the correct head is launched.
- Claim mask: a unit that holds unitReady high for 2 cycles after launch → receives no second ray in the immediately following cycle.
- Reset mid-frame: 3 rays buffered, reset for 1 cycle → no unitStart afterwards, count=0, dispatchCount=0, inReady=1, busy equals |unitBusy.
